// File: rtl/ram_rd_stream_ctrl.sv
// Burst read front end for a 1R1W synchronous RAM: issues per-word requests against reserved
// FIFO credits and streams responses out with a last flag. Optional counters: RAM_RD_STREAM_PERF_EN.
module ram_rd_stream_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned LEN_W     = ADDR_W + 1,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_val,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_rdy,
  output logic              rd_req_en_a,
  output logic [ADDR_W-1:0] rd_req_addr_a,
  input  logic              rd_req_rdy_a,
  input  logic              rd_resp_val_a,
  input  logic [DATA_W-1:0] rd_resp_data_a,
  output logic              rd_resp_rdy_a,
  output logic              data_val,
  output logic [DATA_W-1:0] data,
  output logic              data_last,
  input  logic              data_rdy
`ifdef RAM_RD_STREAM_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_burst_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e              state_q, state_d;
  logic                cmd_rdy_q, cmd_rdy_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    req_cnt_q, req_cnt_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0]     credits_q, credits_d;
  logic                req_en_q, req_en_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;

  logic [DATA_W-1:0]   fifo_q [BUF_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic req_acc;
  logic fifo_wr;
  logic pop;
  logic last_pop;

  assign req_acc  = req_en_q & rd_req_rdy_a;
  // Responses outside a burst are strays; they are dropped rather than buffered.
  assign fifo_wr  = rd_resp_val_a & (state_q != StIdle);
  assign pop      = data_val & data_rdy;
  assign last_pop = pop & data_last;

  assign cmd_rdy       = cmd_rdy_q;
  assign rd_req_en_a   = req_en_q;
  assign rd_req_addr_a = req_addr_q;
  assign rd_resp_rdy_a = 1'b1;
  assign data_val      = (count_q != '0);
  assign data          = fifo_q[rd_ptr_q];
  assign data_last     = data_val & (beat_cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q;
    beat_cnt_d = beat_cnt_q;

    if (req_acc) req_cnt_d = req_cnt_q + LEN_W'(1);
    if (pop)     beat_cnt_d = beat_cnt_q + LEN_W'(1);

    unique case (state_q)
      StIdle: begin
        if (cmd_val && cmd_rdy_q && (cmd_len != '0)) begin
          base_d     = cmd_base_addr;
          len_d      = cmd_len;
          req_cnt_d  = '0;
          beat_cnt_d = '0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (req_acc && (req_cnt_q == len_q - LEN_W'(1))) state_d = StDrain;
      end
      StDrain: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A request accept and a pop in the same cycle cancel out.
    credits_d  = credits_q - CntW'(req_acc) + CntW'(pop);
    req_en_d   = (state_d == StIssue) && (credits_d != '0);
    req_addr_d = base_d + req_cnt_d[ADDR_W-1:0];
    cmd_rdy_d  = (state_d == StIdle);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(fifo_wr) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_rdy_q  <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      req_cnt_q  <= '0;
      beat_cnt_q <= '0;
      credits_q  <= CntW'(BUF_DEPTH);
      req_en_q   <= 1'b0;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_rdy_q  <= cmd_rdy_d;
      base_q     <= base_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      credits_q  <= credits_d;
      req_en_q   <= req_en_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_q[wr_ptr_q] <= rd_resp_data_a;
  end

`ifdef RAM_RD_STREAM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (req_en_q && !rd_req_rdy_a && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (last_pop && (burst_cnt_q != '1))                  burst_cnt_d = burst_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      burst_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_burst_cnt = burst_cnt_q;
`endif

  stray_resp_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_resp_val_a && (state_q == StIdle)));

endmodule

// File: tb/tb_ram_rd_stream_ctrl.sv
// Self-checking bench for ram_rd_stream_ctrl: directed bursts plus randomized bursts checked
// against a queue-based model of the expected word stream and address sequence.
module tb_ram_rd_stream_ctrl;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned BUF_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_val;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_rdy;
  logic              rd_req_en_a;
  logic [ADDR_W-1:0] rd_req_addr_a;
  logic              rd_req_rdy_a;
  logic              rd_resp_val_a;
  logic [DATA_W-1:0] rd_resp_data_a;
  logic              rd_resp_rdy_a;
  logic              data_val;
  logic [DATA_W-1:0] data;
  logic              data_last;
  logic              data_rdy;
`ifdef RAM_RD_STREAM_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_burst_cnt;
  logic [31:0]       stall_before;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_rd_stream_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_val       (cmd_val),
    .cmd_base_addr (cmd_base_addr),
    .cmd_len       (cmd_len),
    .cmd_rdy       (cmd_rdy),
    .rd_req_en_a   (rd_req_en_a),
    .rd_req_addr_a (rd_req_addr_a),
    .rd_req_rdy_a  (rd_req_rdy_a),
    .rd_resp_val_a (rd_resp_val_a),
    .rd_resp_data_a(rd_resp_data_a),
    .rd_resp_rdy_a (rd_resp_rdy_a),
    .data_val      (data_val),
    .data          (data),
    .data_last     (data_last),
    .data_rdy      (data_rdy)
`ifdef RAM_RD_STREAM_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_burst_cnt(perf_burst_cnt)
`endif
  );

  // RAM model: one-cycle read latency, shares the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_val_a  <= 1'b0;
      rd_resp_data_a <= '0;
    end else begin
      rd_resp_val_a  <= rd_req_en_a && rd_req_rdy_a;
      rd_resp_data_a <= mem[rd_req_addr_a];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random readies, 2: full rate with back-to-back check,
  // 4: downstream blocked 10 cycles, 5: RAM refuses the 2nd request for 3 cycles.
  task automatic run_burst(input int base, input int len, input int rdy_pct, input int req_pct,
                           input int mode);
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_w;
    int issued = 0;
    int popped = 0;
    int cyc = 0;
    int stalls = 0;
    int last_pop_cyc = 0;
    bit done = 1'b0;
`ifdef RAM_RD_STREAM_PERF_EN
    logic [31:0] bursts_before;
`endif
    for (int i = 0; i < 20 && cmd_rdy !== 1'b1; i++) step();
    check("cmd_rdy_before_burst", cmd_rdy, 1);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
`ifdef RAM_RD_STREAM_PERF_EN
    bursts_before = perf_burst_cnt;
`endif
    cmd_val       = 1'b1;
    cmd_base_addr = ADDR_W'(base);
    cmd_len       = LEN_W'(len);
    step();
    cmd_val = 1'b0;
    while (!done && cyc < 300) begin
      if (mode == 4)      data_rdy = (cyc >= 10);
      else                data_rdy = ($urandom_range(99) < rdy_pct);
      if (mode == 5)      rd_req_rdy_a = !(issued == 1 && rd_req_en_a && stalls < 3);
      else if (mode == 4) rd_req_rdy_a = 1'b1;
      else                rd_req_rdy_a = ($urandom_range(99) < req_pct);
      if (mode == 5 && rd_req_en_a && !rd_req_rdy_a) stalls++;
      if (mode == 4 && cyc == 10) begin
        check("t4_reqs_while_blocked", issued, BUF_DEPTH);
        check("t4_fifo_holding", data_val, 1);
      end
      if (rd_req_en_a) begin
        if (issued < len) check("req_addr", rd_req_addr_a, (base + issued) % DEPTH);
        else              check("req_beyond_len", issued, len - 1);
        if (rd_req_rdy_a) issued++;
      end
      if (data_val && data_rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", popped, len - 1);
          done = 1'b1;
        end else begin
          exp_w = exp_q.pop_front();
          check("data", data, exp_w);
          check("data_last", data_last, exp_q.size() == 0);
          if (mode == 2 && popped > 0) check("back_to_back", cyc, last_pop_cyc + 1);
          last_pop_cyc = cyc;
          popped++;
          if (exp_q.size() == 0) done = 1'b1;
        end
      end
      check("in_flight_bound", (issued - popped) <= BUF_DEPTH, 1);
      cyc++;
      step();
    end
    check("burst_done", done, 1);
    check("req_total", issued, len);
    check("cmd_rdy_after_last", cmd_rdy, 1);
    check("data_val_after_last", data_val, 0);
`ifdef RAM_RD_STREAM_PERF_EN
    check("perf_burst_inc", perf_burst_cnt - bursts_before, 1);
`endif
    rd_req_rdy_a = 1'b1;
    data_rdy     = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cmd_val       = 1'b0;
    cmd_base_addr = '0;
    cmd_len       = '0;
    rd_req_rdy_a  = 1'b1;
    data_rdy      = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 16);

    // Reset state, then reset asserted mid-ISSUE
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_req_en", rd_req_en_a, 0);
    check("rst_data_val", data_val, 0);
    check("rst_data_last", data_last, 0);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_cmd_rdy", cmd_rdy, 1);
    check("resp_rdy_const", rd_resp_rdy_a, 1);
`ifdef RAM_RD_STREAM_PERF_EN
    check("perf_stall_rst", perf_stall_cnt, 0);
    check("perf_burst_rst", perf_burst_cnt, 0);
`endif
    cmd_val       = 1'b1;
    cmd_base_addr = '0;
    cmd_len       = LEN_W'(8);
    step();
    cmd_val = 1'b0;
    step();
    step();
    check("t1_issue_active", rd_req_en_a, 1);
    check("t1_data_pending", data_val, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_req_en", rd_req_en_a, 0);
    check("t1_async_data_val", data_val, 0);
    check("t1_async_cmd_rdy", cmd_rdy, 0);
    step();
    check("t1_edge_req_en", rd_req_en_a, 0);
    check("t1_edge_data_val", data_val, 0);
    #2 rst_n = 1'b1;
    step();
    check("t1_release_cmd_rdy", cmd_rdy, 1);
    data_rdy = 1'b1;

    // Directed bursts
    run_burst(2, 4, 100, 100, 2);
    run_burst(6, 4, 100, 100, 0);
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_burst(3, 8, 100, 100, 4);
`ifdef RAM_RD_STREAM_PERF_EN
    stall_before = perf_stall_cnt;
`endif
    run_burst(5, 5, 100, 100, 5);
`ifdef RAM_RD_STREAM_PERF_EN
    check("t5_perf_stalls", perf_stall_cnt - stall_before, 3);
`endif

    // Zero-length command is a no-op
    check("t6_cmd_rdy_pre", cmd_rdy, 1);
    cmd_val       = 1'b1;
    cmd_base_addr = ADDR_W'(4);
    cmd_len       = '0;
    step();
    cmd_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t6_no_req", rd_req_en_a, 0);
      check("t6_no_data", data_val, 0);
      check("t6_cmd_rdy", cmd_rdy, 1);
      step();
    end

    // Randomized bursts with random readiness on both sides
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      run_burst(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DEPTH, 1)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
